// File: rtl/fifo_level_pkg.sv
// fifo_level_pkg
//   Shared width helpers and small types for the fifo_level FIFO.
//   cnt_width(depth) : bits needed to hold an occupancy of 0..depth.
//   ptr_width(depth) : bits needed to address entries 0..depth-1.
package fifo_level_pkg;

  // Occupancy counter width; count must reach DEPTH itself, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width; never below one bit so degenerate depths still elaborate.
  function automatic int ptr_width(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Effective per-cycle operation after qualifying the raw requests.
  typedef struct packed {
    logic push;
    logic pop;
  } fifo_op_t;

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem
//   WIDTH x DEPTH register array used as FIFO storage.
//   clk   : write clock
//   we    : write enable, writes wdata to mem[waddr] on the rising edge
//   waddr : write address (0..DEPTH-1)
//   wdata : write data
//   raddr : read address (0..DEPTH-1)
//   rdata : asynchronous read of mem[raddr]
module fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; its contents are only observable through
  // pointers that reset, so resetting the array would cost flops for nothing.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_level.sv
// fifo_level
//   Single-clock show-ahead FIFO with arbitrary depth, occupancy count,
//   programmable almost-full/almost-empty flags and sticky error flags.
//   clk          : clock, all state changes on the rising edge
//   res_n        : asynchronous active-low reset
//   wdata        : write data, taken when shift_in is accepted
//   shift_in     : push request
//   shift_out    : pop request, consumes the word on rdata
//   clear_err    : synchronous clear of overflow/underflow
//   rdata        : head-of-queue word, valid while empty=0
//   count        : occupancy 0..DEPTH
//   full, empty  : count==DEPTH, count==0
//   almost_full  : count >= AF_THRESH
//   almost_empty : count <= AE_THRESH
//   overflow     : sticky, push dropped while full
//   underflow    : sticky, pop requested while empty
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int  WIDTH     = 32,
  parameter int  DEPTH     = 8,
  parameter int  AF_THRESH = DEPTH - 1,
  parameter int  AE_THRESH = 1,
  localparam int CW        = cnt_width(DEPTH),
  localparam int PW        = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             shift_in,
  input  logic             shift_out,
  input  logic             clear_err,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  // Elaboration-time parameter checks.
  if (DEPTH < 2) begin : g_bad_depth
    $error("fifo_level: DEPTH must be >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("fifo_level: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("fifo_level: AE_THRESH must be in 0..DEPTH-1");
  end

  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  logic [PW-1:0] write_ptr;
  logic [PW-1:0] read_ptr;
  logic [CW-1:0] count_nxt;
  fifo_op_t      op;

  // A push while full is legal only when the head is leaving the same cycle;
  // full implies non-empty, so that pop is always real.
  assign op.push = shift_in & (~full | shift_out);
  assign op.pop  = shift_out & ~empty;

  // NOTE: combinational block gives count_nxt a default first so no latch
  // is inferred on the paths that leave it unchanged.
  always_comb begin
    count_nxt = count;
    if (op.push && !op.pop)      count_nxt = count + 1'b1;
    else if (op.pop && !op.push) count_nxt = count - 1'b1;
  end

  // Flags are registered from count_nxt so they always agree with count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      write_ptr    <= '0;
      read_ptr     <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= (AF_THRESH == 0);
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (op.push) write_ptr <= (write_ptr == LAST_IDX) ? '0 : write_ptr + 1'b1;
      if (op.pop)  read_ptr  <= (read_ptr == LAST_IDX) ? '0 : read_ptr + 1'b1;
      count        <= count_nxt;
      full         <= (count_nxt == CW'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CW'(AF_THRESH));
      almost_empty <= (count_nxt <= CW'(AE_THRESH));
      // Set has priority over clear_err.
      overflow     <= (shift_in & full & ~shift_out) | (overflow & ~clear_err);
      underflow    <= (shift_out & empty) | (underflow & ~clear_err);
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (op.push),
    .waddr (write_ptr),
    .wdata (wdata),
    .raddr (read_ptr),
    .rdata (rdata)
  );

endmodule

// File: doc/fifo_level.md
# fifo_level

Parametrised synchronous FIFO, the next generation of the team's single-clock FIFO. It adds arbitrary (non-power-of-two) depth, well-defined simultaneous push/pop, an occupancy counter, and programmable almost-full/almost-empty flags. It also adds sticky overflow/underflow error flags. It sits between producer and consumer blocks in the same clock domain and presents show-ahead (first-word-fall-through) read data.

## Interface
- `WIDTH`, 32: data word width in bits.
- `DEPTH`, 8: number of entries; any integer ≥ 2.
- `AF_THRESH`, DEPTH-1: `almost_full` asserts when count ≥ AF_THRESH; legal range 1..DEPTH.
- `AE_THRESH`, 1: `almost_empty` asserts when count ≤ AE_THRESH; legal range 0..DEPTH-1.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `res_n`  in  1  asynchronous, active-low reset.
- `wdata`  in  WIDTH  write data, sampled with `shift_in`.
- `shift_in`  in  1  push request.
- `shift_out`  in  1  pop request; consumes the word currently on `rdata`.
- `clear_err`  in  1  synchronous clear of `overflow`/`underflow`.
- `rdata`  out  WIDTH  head-of-queue word; valid whenever `empty`=0.
- `count`  out  log2(DEPTH+1)  current occupancy, 0..DEPTH.
- `full`, `empty`  out  1  count==DEPTH, count==0.
- `almost_full`, `almost_empty`  out  1  threshold flags.
- `overflow`, `underflow`  out  1  sticky error flags.

## Operation
- Reset (async assert, sync release): `write_ptr`=`read_ptr`=0, `count`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=(AF_THRESH==0 ? 1 : 0), which is always 0 for legal values. `overflow`=`underflow`=0. `rdata` is don't-care while `empty`=1.
- Pointers wrap explicitly: DEPTH-1 → 0. Modulo-2^n wrap is not used.
- The effective operations per cycle are `push = shift_in & (!full | shift_out)` and `pop = shift_out & !empty`:
  - push only: write `mem[write_ptr]`, advance `write_ptr`, count+1.
  - pop only: advance `read_ptr`, count−1.
  - push and pop: write and advance both pointers; count unchanged. This is legal when full.
  - `shift_in` while full without `shift_out`: word dropped; `overflow` set.
  - `shift_out` while empty: no pointer change; `underflow` set. A simultaneous `shift_in` is still accepted. There is no bypass: the new word appears on `rdata` the next cycle.
- All flags (`full`, `empty`, `almost_*`) are registers. Each is computed from the next count value, so it is consistent with `count` in the same cycle.
- `overflow`/`underflow` stay set until `clear_err` or reset. If a set event and `clear_err` occur in the same cycle, set wins.
- Storage is written only on push. `rdata` is an asynchronous read of `mem[read_ptr]`.
- The `DEBUG` build prints a warning on drop, on underflow, and on any shift request while `res_n`=0.

## Timing
- Write-to-read latency is one edge. A word pushed into an empty FIFO at edge N is on `rdata` with `empty`=0 after edge N.
- The pop at edge N exposes the next word on `rdata` after edge N, with no bubble.
- Full throughput: one push and one pop every cycle, indefinitely, at any occupancy.
- There are no combinational paths from `shift_in`/`shift_out` to any output. Flags and `count` are registered; `rdata` depends only on `read_ptr` and memory.
- If reset is asserted mid-stream, contents are lost immediately and the flags return to their reset values asynchronously. Requests in the release cycle are honoured normally.

## Structure
- Shared include file: `log2` (existing `log.v`) for pointer and count widths, plus a `clog2`-of-(DEPTH+1) helper for `count`.
- Elaboration checks abort on DEPTH<2, AF_THRESH outside 1..DEPTH, or AE_THRESH outside 0..DEPTH-1.
- One sub-module, `fifo_mem`: a WIDTH×DEPTH register array with a synchronous write port and an asynchronous read port. Pointer, count, flag and error logic stay in `fifo_level`.

## Test plan
All scenarios use WIDTH=8, DEPTH=5, AF_THRESH=4, AE_THRESH=1.
- **Fill from reset:** push 0x11..0x55 on 5 cycles → `count` 1,2,3,4,5. `almost_empty` clears at count 2, `almost_full` sets at 4, `full` at 5. `rdata`=0x11 throughout.
- **Overflow:** sixth push 0x66 while full → `count` stays 5, `overflow`=1. Draining yields 0x11..0x55 exactly (0x66 is absent); `empty`=1 after the fifth pop.
- **Simultaneous push/pop:**
  - Full, push 0xA0 with pop → `count`=5, `overflow`=0, and 0xA0 is read out after 4 further pops.
  - At count 2, 20 cycles of push+pop → `count` stays 2 and order is preserved across pointer wrap at index 4 → 0.
- **Empty edge cases:**
  - Pop while empty → `underflow`=1, `count`=0.
  - Push 0x77 with pop while empty → `count`=1, `rdata`=0x77 next cycle, `underflow`=1.
  - `clear_err` → both error flags 0 the following cycle.
- **Reset mid-operation:** at count 3, drop `res_n` asynchronously between edges → `empty`=1, `count`=0, `full`=0 before the next edge. After release, push 0x99 → `rdata`=0x99.
- **Randomised scoreboard (10k cycles, random `shift_in`/`shift_out`):** check every `rdata`, `count` and flag against a reference queue model.
